instr_loader: RTL

Program loader that fills the 40-bit instruction memory from a byte stream, the write-side counterpart of the instruction ROM read port. It accepts bytes over a valid/ready handshake, packs them MSB-first into INSTRUCTION_WIDTH-bit words, and issues one memory write per completed word at consecutive addresses from 0. It sits between the host/serial front end and the instruction memory write port. It holds the CPU in reset (cpu_hold) while a load is in progress.

---
 rtl/instr_loader_pkg.sv | 18 +
 rtl/instr_loader_byte_packer.sv | 54 +++++
 rtl/instr_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and default widths for the instruction-memory program loader.
package instr_loader_pkg;

  localparam int DEF_INSTRUCTION_WIDTH = 40;
  localparam int DEF_PC_WIDTH          = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/instr_loader_byte_packer.sv
// MSB-first byte packer: shifts stream bytes into a word and flags the last byte of each word.
module byte_packer
  import instr_loader_pkg::*;
#(
  parameter int WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int BYTES = bytes_per_word(DEF_INSTRUCTION_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic [7:0]       byte_i,
  output logic [WIDTH-1:0] word_o,
  output logic             last_byte_o
);

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [WIDTH-1:0] shift_q, shift_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Oldest byte migrates toward the MSB as later bytes are appended.
  if (WIDTH > 8) begin : g_wide
    assign shifted = {shift_q[WIDTH-9:0], byte_i};
  end else begin : g_narrow
    assign shifted = byte_i;
  end

  assign last_byte_o = (cnt_q == CW'(BYTES - 1));
  assign word_o      = shift_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_i) begin
      shift_d = shifted;
      cnt_d   = last_byte_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads the instruction memory from a byte stream, one write per packed word, holding the CPU meanwhile.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int PC_WIDTH          = DEF_PC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PC_WIDTH:0]            num_words,
  input  logic                         abort,
  input  logic [7:0]                   byte_data,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic                         mem_we,
  output logic [PC_WIDTH-1:0]          mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
  output logic                         busy,
  output logic                         cpu_hold,
  output logic                         done,
  output logic [PC_WIDTH:0]            words_written
);

  localparam int BYTES = bytes_per_word(INSTRUCTION_WIDTH);
  localparam logic [PC_WIDTH:0] MAX_WORDS = {1'b1, {PC_WIDTH{1'b0}}};

  if ((INSTRUCTION_WIDTH % 8) != 0 || INSTRUCTION_WIDTH < 8) begin : g_width_check
    $fatal(1, "instr_loader: INSTRUCTION_WIDTH must be a positive multiple of 8");
  end

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    addr_q, addr_d;
  logic [PC_WIDTH:0]      ww_q, ww_d;
  logic [PC_WIDTH:0]      target_q, target_d;
  logic [PC_WIDTH:0]      clamped;
  logic                   pk_clear, pk_shift, last_byte;
  logic [INSTRUCTION_WIDTH-1:0] packed_word;

  assign clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;

  byte_packer #(
    .WIDTH(INSTRUCTION_WIDTH),
    .BYTES(BYTES)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (pk_clear),
    .shift_i    (pk_shift),
    .byte_i     (byte_data),
    .word_o     (packed_word),
    .last_byte_o(last_byte)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ww_d     = ww_q;
    target_d = target_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = '0;
          ww_d     = '0;
          target_d = clamped;
          pk_clear = 1'b1;
          state_d  = (clamped == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        // Abort wins over a coincident byte so a partial word never reaches memory.
        if (abort) begin
          state_d = IDLE;
        end else if (byte_valid) begin
          pk_shift = 1'b1;
          if (last_byte) state_d = WRITE;
        end
      end
      WRITE: begin
        ww_d   = ww_q + 1'b1;
        addr_d = addr_q + 1'b1;
        if (abort)                         state_d = IDLE;
        else if ((ww_q + 1'b1) == target_q) state_d = DONE;
        else                               state_d = COLLECT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      ww_q     <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ww_q     <= ww_d;
      target_q <= target_d;
    end
  end

  assign byte_ready    = (state_q == COLLECT);
  assign mem_we        = (state_q == WRITE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = mem_we ? packed_word : '0;
  assign busy          = (state_q == COLLECT) || (state_q == WRITE);
  assign cpu_hold      = busy;
  assign done          = (state_q == DONE);
  assign words_written = ww_q;

endmodule
